// File: rtl/coa_bus_pkg.sv
// Shared definitions for the register-transfer bus: FSM encodings, bus width, index-width helper.
package coa_bus_pkg;

    localparam int BUS_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2,
        ACK   = 2'd3
    } xfer_state_e;

    // Minimum index width for v items, evaluable at elaboration time.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_xfer_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1, with wrap.
// Zero latency; any=0 when no request is pending.
module rr_pick #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] grant_idx,
    output logic            any
);

    logic [IDXW-1:0] idx;

    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        idx       = ptr;
        for (int k = 0; k < N; k++) begin
            // Explicit wrap so non-power-of-two N never indexes past N-1.
            idx = (idx == IDXW'(N - 1)) ? '0 : idx + 1'b1;
            if (!any && req[idx]) begin
                any       = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/bus_xfer_arbiter.sv
// Round-robin sequencer for register-to-register transfers on the shared bus (DRIVE, LOAD, ACK).
// Grant to first t_en is one cycle; ack three cycles after grant, or one cycle for a rejected request.
module bus_xfer_arbiter
    import coa_bus_pkg::*;
#(
    parameter  int N    = 4,
    localparam int IDXW = clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic [N*IDXW-1:0]   dst,
    output logic [N-1:0]        t_en,
    output logic [N-1:0]        l_en,
    output logic [N-1:0]        ack,
    output logic                err,
    output logic                busy
);

    localparam logic [IDXW:0] N_W = (IDXW + 1)'(N);

    xfer_state_e     state_q, state_d;
    logic [IDXW-1:0] src_q, src_d;
    logic [IDXW-1:0] d_q, d_d;
    logic            rej_q, rej_d;
    logic [IDXW-1:0] ptr_q, ptr_d;

    logic [N-1:0]    t_en_q, t_en_d;
    logic [N-1:0]    l_en_q, l_en_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic [IDXW-1:0] grant_idx;
    logic            any;
    logic [IDXW-1:0] dsel;
    logic [N-1:0]    src_oh, d_oh;

    rr_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req       (req),
        .ptr       (ptr_q),
        .grant_idx (grant_idx),
        .any       (any)
    );

    always_comb begin
        dsel = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == IDXW'(i)) dsel = dst[i*IDXW +: IDXW];
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        d_d     = d_q;
        rej_d   = rej_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    src_d   = grant_idx;
                    d_d     = dsel;
                    rej_d   = (dsel == grant_idx) || ({1'b0, dsel} >= N_W);
                    state_d = rej_d ? ACK : DRIVE;
                end
            end
            DRIVE:   state_d = LOAD;
            LOAD:    state_d = ACK;
            ACK: begin
                ptr_d   = src_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the next state so every strobe leaves a flop in the cycle it applies to.
    always_comb begin
        src_oh = '0;
        d_oh   = '0;
        for (int i = 0; i < N; i++) begin
            src_oh[i] = (src_d == IDXW'(i));
            d_oh[i]   = (d_d == IDXW'(i));
        end
        t_en_d = (state_d == DRIVE || state_d == LOAD) ? src_oh : '0;
        l_en_d = (state_d == LOAD) ? d_oh : '0;
        ack_d  = (state_d == ACK) ? src_oh : '0;
        err_d  = (state_d == ACK) && rej_d;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            d_q     <= '0;
            rej_q   <= 1'b0;
            ptr_q   <= IDXW'(N - 1);
            t_en_q  <= '0;
            l_en_q  <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            d_q     <= d_d;
            rej_q   <= rej_d;
            ptr_q   <= ptr_d;
            t_en_q  <= t_en_d;
            l_en_q  <= l_en_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign t_en = t_en_q;
    assign l_en = l_en_q;
    assign ack  = ack_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule
